utf16_byte_encoder: RTL and testbench
=====================================

// Module: utf16_byte_encoder
// PURPOSE
//   Downstream stage of the UTF-8 decoder. Takes one decoded code point per
//   valid/ready handshake and emits the UTF-16 encoding as an 8-bit byte stream
//   (BE or LE, chosen per character), forming surrogate pairs above U+FFFF.
//   Out-of-range and surrogate code points are replaced, or dropped, and counted.
// PARAMETERS
//   REPLACE      1        1: invalid cp emits REPL_UNIT; 0: invalid cp emits nothing
//   REPL_UNIT    16'hFFFD replacement code unit for invalid input
//   CNT_W        8        width of saturating invalid counter
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rst_n        in   1      async active-low reset
//   cp_in        in   32     code point (full 31-bit range from decoder, bit31 = 0)
//   cp_le        in   1      1: little-endian output for this char; sampled on accept
//   cp_valid     in   1      cp_in/cp_le valid
//   cp_ready     out  1      encoder can accept a code point this cycle
//   out_byte     out  8      output byte
//   out_valid    out  1      out_byte valid
//   out_ready    in   1      consumer takes out_byte when out_valid & out_ready
//   out_last     out  1      out_byte is final byte of current character
//   err_invalid  out  1      sticky: an invalid cp has been accepted since clear
//   err_count    out  CNT_W  invalid cps accepted, saturates at all-ones
//   err_clr      in   1      sync clear of err_invalid and err_count
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; out_valid=0, out_byte=0, out_last=0,
//     err_invalid=0, err_count=0; cp_ready=1 (combinational from IDLE).
//   Classification of accepted cp:
//     cp<=0xFFFF and not 0xD800..0xDFFF -> 1 unit U=cp[15:0], 2 bytes
//     0x10000..0x10FFFF -> v=cp-0x10000 (20 b); H=0xD800|v[19:10], L=0xDC00|v[9:0], 4 bytes
//     0xD800..0xDFFF or >0x10FFFF -> invalid: REPLACE=1 -> 1 unit REPL_UNIT, 2 bytes;
//       REPLACE=0 -> 0 bytes, char consumed, nothing emitted
//   Byte order per unit: cp_le=0 -> [15:8] then [7:0]; cp_le=1 -> [7:0] then [15:8].
//     Pairs always emit H before L (byte order applies within each unit).
//   States: IDLE (no char held); EMIT (idx 0..N-1 of N=2|4 bytes held in regs).
//     IDLE: cp_valid -> latch units, N, cp_le; EMIT idx=0 (dropped invalid stays IDLE).
//     EMIT: out_valid=1; on out_valid&out_ready: idx<N-1 -> idx+1; idx=N-1 -> IDLE,
//       or directly EMIT idx=0 of next char if cp_valid accepted same cycle.
//   cp_ready = IDLE | (out_valid & out_ready & out_last). Back-to-back chars
//     stream with no bubble; cp_ready is combinational from out_ready.
//   Latency: accept in cycle T -> first byte out_valid in T+1 (registered outputs).
//   out_byte/out_last stable while out_valid & !out_ready; out_valid never drops
//     until taken. out_last=1 only on byte N-1.
//   err_invalid set / err_count +1 (sat) on the accept cycle of an invalid cp,
//     regardless of REPLACE. err_clr same cycle as invalid accept: clear wins, then
//     count resets to 0 (the new error is discarded), err_invalid=0.
//   Reset mid-character: remaining bytes discarded, back to reset values.
//   cp_valid while !cp_ready: ignored (upstream holds).
// TESTING
//   cp=0x41, le=0, out_ready=1 -> bytes 0x00,0x41; out_last on 2nd; cp_ready=1 throughout
//   cp=0x1F600, le=0 -> 0xD8,0x3D,0xDE,0x00; le=1 -> 0x3D,0xD8,0x00,0xDE
//   cp=0xD800 then 0x110000, REPLACE=1 -> FF FD FF FD; err_invalid=1, err_count=2;
//     REPLACE=0 -> no bytes, count=2; err_clr -> 0
//   out_ready toggled 0/1 random over 3-char stream 0x7F,0x10FFFF,0x20AC -> exactly
//     00 7F DB FF DF FF 20 AC; no byte dup/loss; stable while stalled
//   cp_valid held with 2-byte chars, out_ready=1 -> one byte per cycle, no bubble
//   rst_n low after 1st byte of 0x1F600 -> out_valid=0 next; following 0x41 clean;
//     256 invalid cps with CNT_W=8 -> err_count sticks at 0xFF

Source files
------------

// File: rtl/utf16_byte_encoder.sv
// UTF-16 byte-stream encoder: one code point per handshake in, 2 or 4 bytes out
// (BE or LE per character), with surrogate pairs and invalid-input replacement/drop.
module utf16_byte_encoder #(
  parameter bit          REPLACE   = 1'b1,
  parameter logic [15:0] REPL_UNIT = 16'hFFFD,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cp_in,
  input  logic             cp_le,
  input  logic             cp_valid,
  output logic             cp_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             err_invalid,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [3:0][7:0]  bytes_q, bytes_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       last_idx_q, last_idx_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_last_q, out_last_d;
  logic             err_invalid_q, err_invalid_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Classification of the incoming code point
  logic            is_surr, is_big, is_invalid, is_pair, new_emit;
  logic [20:0]     v_full;
  logic [15:0]     unit_h, unit_l, unit0;
  logic [3:0][7:0] new_bytes;
  logic [1:0]      new_last;

  assign is_surr    = (cp_in[31:11] == 21'h00001B);
  assign is_big     = (cp_in > 32'h0010_FFFF);
  assign is_invalid = is_surr | is_big;
  assign is_pair    = ~is_invalid & (|cp_in[20:16]);
  assign new_emit   = ~is_invalid | REPLACE;

  assign v_full = cp_in[20:0] - 21'h01_0000;
  assign unit_h = {6'b110110, v_full[19:10]};
  assign unit_l = {6'b110111, v_full[9:0]};
  assign unit0  = is_invalid ? REPL_UNIT : (is_pair ? unit_h : cp_in[15:0]);

  assign new_bytes[0] = cp_le ? unit0[7:0]  : unit0[15:8];
  assign new_bytes[1] = cp_le ? unit0[15:8] : unit0[7:0];
  assign new_bytes[2] = cp_le ? unit_l[7:0]  : unit_l[15:8];
  assign new_bytes[3] = cp_le ? unit_l[15:8] : unit_l[7:0];
  assign new_last     = is_pair ? 2'd3 : 2'd1;

  // Handshakes
  logic out_fire, last_fire, accept, load, inv_accept;
  logic [1:0] idx_nxt;

  assign out_valid  = (state_q == StEmit);
  assign out_fire   = out_valid & out_ready;
  assign last_fire  = out_fire & out_last_q;
  // Combinational from out_ready so a new character can follow with no bubble
  assign cp_ready   = (state_q == StIdle) | last_fire;
  assign accept     = cp_valid & cp_ready;
  assign load       = accept & new_emit;
  assign inv_accept = accept & is_invalid;
  assign idx_nxt    = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    bytes_d    = bytes_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    out_byte_d = out_byte_q;
    out_last_d = out_last_q;
    if (load) begin
      state_d    = StEmit;
      bytes_d    = new_bytes;
      last_idx_d = new_last;
      idx_d      = 2'd0;
      out_byte_d = new_bytes[0];
      out_last_d = 1'b0;
    end else if (last_fire) begin
      state_d    = StIdle;
      idx_d      = 2'd0;
      out_byte_d = 8'h00;
      out_last_d = 1'b0;
    end else if (out_fire) begin
      idx_d      = idx_nxt;
      out_byte_d = bytes_q[idx_nxt];
      out_last_d = (idx_nxt == last_idx_q);
    end
  end

  // Clear has priority over a same-cycle invalid accept
  always_comb begin
    err_invalid_d = err_invalid_q;
    err_count_d   = err_count_q;
    if (err_clr) begin
      err_invalid_d = 1'b0;
      err_count_d   = '0;
    end else if (inv_accept) begin
      err_invalid_d = 1'b1;
      if (!(&err_count_q)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bytes_q       <= '0;
      idx_q         <= 2'd0;
      last_idx_q    <= 2'd0;
      out_byte_q    <= 8'h00;
      out_last_q    <= 1'b0;
      err_invalid_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      bytes_q       <= bytes_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      out_byte_q    <= out_byte_d;
      out_last_q    <= out_last_d;
      err_invalid_q <= err_invalid_d;
      err_count_q   <= err_count_d;
    end
  end

  assign out_byte    = out_byte_q;
  assign out_last    = out_last_q;
  assign err_invalid = err_invalid_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_utf16_byte_encoder.sv
// Randomized bench for utf16_byte_encoder: a code-point-level UTF-16 model predicts the
// byte stream, handshake and error counters of a replacing and a dropping instance.
module tb_utf16_byte_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] cp_in = '0;
  logic        cp_le = 1'b0;
  logic        cp_valid = 1'b0;
  logic        cp_valid0 = 1'b0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic       cp_ready, out_valid, out_last, err_invalid;
  logic [7:0] out_byte, err_count;
  logic       cp_ready0, out_valid0, out_last0, err_invalid0;
  logic [7:0] out_byte0, err_count0;

  always #5 clk = ~clk;

  utf16_byte_encoder u_dut (
    .clk(clk), .rst_n(rst_n), .cp_in(cp_in), .cp_le(cp_le), .cp_valid(cp_valid),
    .cp_ready(cp_ready), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .err_invalid(err_invalid), .err_count(err_count), .err_clr(err_clr)
  );

  utf16_byte_encoder #(.REPLACE(1'b0)) u_dut_drop (
    .clk(clk), .rst_n(rst_n), .cp_in(cp_in), .cp_le(cp_le), .cp_valid(cp_valid0),
    .cp_ready(cp_ready0), .out_byte(out_byte0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_last(out_last0), .err_invalid(err_invalid0),
    .err_count(err_count0), .err_clr(err_clr)
  );

  typedef struct {logic [31:0] cp; logic le;} chr_t;

  int          n_tests = 0;
  int          n_fail = 0;
  chr_t        pend[$];
  logic [31:0] pend0[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  got[$];
  logic [7:0]  ref_seq[$];
  int unsigned e_cnt = 0, e0_cnt = 0;
  bit          e_inv = 0, e0_inv = 0;
  bit          or_rand = 0, gap_rand = 0, clr_rand = 0, clr_once = 0;
  bit          stall = 0;
  logic [7:0]  stall_byte;
  logic        stall_last;
  logic [31:0] bnd [8] = '{32'h0, 32'hFFFF, 32'hD7FF, 32'hE000, 32'h10000, 32'h10FFFF,
                           32'h110000, 32'hDFFF};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_inv(input logic [31:0] cp);
    return (cp >= 32'hD800 && cp <= 32'hDFFF) || cp > 32'h10FFFF;
  endfunction

  function automatic int unsigned sat(input int unsigned c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // Expected bytes of one character on the replacing instance
  function automatic void model_push(input logic [31:0] cp, input logic le);
    int unsigned units[$];
    int unsigned v, hi, lo;
    logic [7:0]  b0, b1;
    logic        lst;
    if (is_inv(cp)) units.push_back(32'hFFFD);
    else if (cp < 32'h10000) units.push_back(cp);
    else begin
      v = cp - 32'h10000;
      units.push_back(32'hD800 + v / 1024);
      units.push_back(32'hDC00 + v % 1024);
    end
    foreach (units[i]) begin
      hi  = units[i] / 256;
      lo  = units[i] % 256;
      b0  = le ? 8'(lo) : 8'(hi);
      b1  = le ? 8'(hi) : 8'(lo);
      lst = (i == units.size() - 1);
      exp_q.push_back({1'b0, b0});
      exp_q.push_back({lst, b1});
    end
  endfunction

  function automatic logic [31:0] rand_cp();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 32'h7F));
      1: return 32'($urandom_range(0, 32'hFFFF));
      2: return 32'($urandom_range(32'h10000, 32'h10FFFF));
      3: return 32'($urandom_range(32'hD800, 32'hDFFF));
      4: return $urandom() & 32'h7FFF_FFFF;
      default: return bnd[$urandom_range(0, 7)];
    endcase
  endfunction

  task automatic step();
    logic [8:0] e;
    bit acc, acc0;
    @(negedge clk);
    out_ready = or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    err_clr   = clr_once || (clr_rand && $urandom_range(0, 15) == 0);
    clr_once  = 0;
    cp_valid  = 1'b0;
    cp_valid0 = 1'b0;
    cp_in     = $urandom() & 32'h7FFF_FFFF;
    cp_le     = 1'($urandom());
    if (pend0.size() > 0) begin
      cp_valid0 = 1'b1;
      cp_in     = pend0[0];
    end else if (pend.size() > 0 && !(gap_rand && $urandom_range(0, 3) == 0)) begin
      cp_valid = 1'b1;
      cp_in    = pend[0].cp;
      cp_le    = pend[0].le;
    end
    #1;
    check("err_count", err_count, e_cnt);
    check("err_invalid", err_invalid, e_inv);
    check("drop_err_count", err_count0, e0_cnt);
    check("drop_err_invalid", err_invalid0, e0_inv);
    check("drop_out_valid", out_valid0, 0);
    check("drop_cp_ready", cp_ready0, 1);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("cp_ready", cp_ready, (exp_q.size() == 0) || (out_ready && exp_q.size() == 1));
    if (stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_byte", out_byte, stall_byte);
      check("stall_last", out_last, stall_last);
    end
    stall      = out_valid && !out_ready;
    stall_byte = out_byte;
    stall_last = out_last;
    if (out_valid && out_ready) begin
      got.push_back(out_byte);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("byte", out_byte, e[7:0]);
        check("last", out_last, e[8]);
      end else check("extra_byte", out_byte, 32'hFFFF_FFFF);
    end
    acc  = cp_valid && cp_ready;
    acc0 = cp_valid0 && cp_ready0;
    if (acc) begin
      model_push(cp_in, cp_le);
      pend.delete(0);
    end
    if (acc0) pend0.delete(0);
    if (err_clr) begin
      e_cnt = 0; e_inv = 0; e0_cnt = 0; e0_inv = 0;
    end else begin
      if (acc && is_inv(cp_in)) begin e_cnt = sat(e_cnt); e_inv = 1; end
      if (acc0 && is_inv(cp_in)) begin e0_cnt = sat(e0_cnt); e0_inv = 1; end
    end
  endtask

  task automatic drain(input int max_cyc, output int cyc);
    cyc = 0;
    while ((pend.size() > 0 || pend0.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
      step();
      cyc++;
    end
    if (pend.size() > 0 || pend0.size() > 0 || exp_q.size() > 0) begin
      check("drain_timeout", cyc, 32'hFFFF_FFFF);
      pend.delete(); pend0.delete(); exp_q.delete();
    end
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, got.size(), ref_seq.size());
    for (int i = 0; i < got.size() && i < ref_seq.size(); i++) check(tag, got[i], ref_seq[i]);
    got.delete();
  endtask

  task automatic push_chr(input logic [31:0] cp, input logic le);
    chr_t c;
    c.cp = cp;
    c.le = le;
    pend.push_back(c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_invalid", err_invalid, 0);
    check("rst_err_count", err_count, 0);
    check("rst_cp_ready", cp_ready, 1);
    rst_n = 1'b1;

    push_chr(32'h41, 1'b0);
    drain(50, cyc);
    ref_seq = {8'h00, 8'h41};
    check_seq("seq_41");

    push_chr(32'h1F600, 1'b0);
    drain(50, cyc);
    ref_seq = {8'hD8, 8'h3D, 8'hDE, 8'h00};
    check_seq("seq_1f600_be");
    push_chr(32'h1F600, 1'b1);
    drain(50, cyc);
    ref_seq = {8'h3D, 8'hD8, 8'h00, 8'hDE};
    check_seq("seq_1f600_le");

    clr_once = 1;
    step();
    got.delete();
    push_chr(32'hD800, 1'b0);
    push_chr(32'h110000, 1'b0);
    drain(50, cyc);
    ref_seq = {8'hFF, 8'hFD, 8'hFF, 8'hFD};
    check_seq("seq_repl");
    check("repl_err_invalid", err_invalid, 1);
    check("repl_err_count", err_count, 2);

    clr_once = 1;
    step();
    pend0.push_back(32'hD800);
    pend0.push_back(32'h110000);
    drain(50, cyc);
    step();
    check("drop_count2", err_count0, 2);
    check("drop_invalid1", err_invalid0, 1);
    clr_once = 1;
    step();
    step();
    check("drop_clr_count", err_count0, 0);
    check("drop_clr_invalid", err_invalid0, 0);
    got.delete();

    or_rand = 1;
    push_chr(32'h7F, 1'b0);
    push_chr(32'h10FFFF, 1'b0);
    push_chr(32'h20AC, 1'b0);
    drain(200, cyc);
    ref_seq = {8'h00, 8'h7F, 8'hDB, 8'hFF, 8'hDF, 8'hFF, 8'h20, 8'hAC};
    check_seq("seq_stall");
    or_rand = 0;

    // Back-to-back 2-byte chars: one accept cycle, then one byte per cycle
    while (stall) step();
    for (int i = 0; i < 6; i++) push_chr(32'($urandom_range(0, 32'hD7FF)), 1'($urandom()));
    drain(100, cyc);
    check("b2b_cycles", cyc, 13);
    got.delete();

    push_chr(32'h1F600, 1'b0);
    cyc = 0;
    while (got.size() == 0 && cyc < 20) begin step(); cyc++; end
    check("rst_mid_first", got.size(), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    pend.delete(); exp_q.delete(); got.delete();
    stall = 0; e_cnt = 0; e_inv = 0; e0_cnt = 0; e0_inv = 0;
    @(negedge clk);
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_byte", out_byte, 0);
    check("rst_mid_ready", cp_ready, 1);
    rst_n = 1'b1;
    push_chr(32'h41, 1'b0);
    drain(50, cyc);
    ref_seq = {8'h00, 8'h41};
    check_seq("seq_after_rst");

    for (int i = 0; i < 256; i++)
      pend0.push_back((i % 2 == 1) ? 32'hD800 + 32'(i) : 32'h110000 + 32'(i) * 977);
    drain(1000, cyc);
    step();
    check("drop_sat", err_count0, 8'hFF);
    for (int i = 0; i < 256; i++)
      push_chr((i % 2 == 1) ? 32'hDC00 + 32'(i) : 32'h7FFF_0000 + 32'(i), 1'($urandom()));
    drain(2000, cyc);
    step();
    check("repl_sat", err_count, 8'hFF);
    got.delete();

    or_rand = 1; gap_rand = 1; clr_rand = 1;
    for (int i = 0; i < 400; i++) push_chr(rand_cp(), 1'($urandom()));
    drain(20000, cyc);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
